// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the rv32i pipeline.
// Holds the PC, addresses the combinational instruction memory and captures
// the returned word, its PC and PC+4 into the IF/ID register. Supports
// hazard stall, EX-resolved redirect and a halt-on-zero-word policy.
//
// Flow semantics: if_id_valid marks IF/ID as holding a real instruction.
// Downstream back-pressure is the stall input. While stall is high and no
// redirect is present, IF/ID, the PC and the state hold unchanged, so an
// instruction is neither dropped nor duplicated. A redirect always wins
// over stall and replaces IF/ID with a bubble (valid=0, instr=addi x0,x0,0).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_AW      = 10,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               r,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic [31:0]        if_id_instr,
    output logic               if_id_valid,
    output logic               halted
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        zero_hit;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign zero_hit  = HALT_ON_ZERO && (imem_instr == 32'h0000_0000);

    // State register: reset forces RUN.
    always_ff @(posedge clk) begin
        if (r) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: redirect > stall > zero-word halt detection.
    always_comb begin
        next_state = state;
        if (redirect) begin
            next_state = RUN;
        end else if (stall) begin
            next_state = state;
        end else if (state == RUN && zero_hit) begin
            next_state = HALT;
        end
    end

    // Output logic: halted mirrors the HALT state.
    always_comb begin
        halted = 1'b0;
        if (state == HALT) begin
            halted = 1'b1;
        end
    end

    // PC and IF/ID register: r > redirect > stall > halt/zero bubble > normal.
    always_ff @(posedge clk) begin
        if (r) begin
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_pc4   <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
            if_id_valid <= if_id_valid;
        end else if (state == HALT || zero_hit) begin
            // PC parks on the zero word; only redirect or reset moves it.
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
        end
    end

endmodule
